// File: rtl/at24c02_pkg.sv
// at24c02_pkg
// Shared definitions for the AT24C02-style I2C EEPROM model: default
// parameter values and the protocol FSM state encoding.
package at24c02_pkg;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;
  localparam int         DEF_ADDR_W     = 11;
  localparam int         DEF_PAGE_SIZE  = 16;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    ADDR_H,
    ADDR_H_ACK,
    ADDR_L,
    ADDR_L_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

endpackage

// File: rtl/at24c02_model_i2c_bus_sync.sv
// i2c_bus_sync
// Brings the asynchronous I2C lines into the clk domain and decodes
// bus events from the synchronized values.
// Ports:
//   clk, rst            system clock, async active-low reset
//   scl_i, sda_i        raw bus lines
//   sda                 synchronized SDA level
//   scl_rise, scl_fall  one-cycle pulses on synchronized SCL edges
//   start_det, stop_det one-cycle pulses on START / STOP conditions
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Idle bus level is high, so every flop resets to 1 and no edge or
  // condition is seen when reset releases on a quiet bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda       = sda_ff[1];
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SCL must be high on both samples so an SDA change racing an SCL edge
  // is not mistaken for a bus condition.
  assign start_det = scl_s & scl_d &  sda_d & ~sda;
  assign stop_det  = scl_s & scl_d & ~sda_d &  sda;

endmodule

// File: rtl/at24c02_model.sv
// at24c02_model
// Behavioural-but-synthesizable I2C serial EEPROM slave with a backdoor
// port for test access. Page-wrapped writes, auto-incrementing reads.
// Ports:
//   clk, rst          system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i      I2C bus inputs
//   sda_o, sda_oe     open-drain drive: sda_o is always 0, sda_oe pulls low
//   bd_we, bd_addr,
//   bd_wdata          backdoor write port
//   bd_rdata          backdoor read data, one cycle after bd_addr
//   busy              high from START until STOP
//
// state      | meaning
// IDLE       | ignore bus until START
// DEV_ADDR   | shifting in device address + R/W
// DEV_ACK    | acknowledging device address
// ADDR_H     | shifting in word-address high byte
// ADDR_H_ACK | acknowledging high byte
// ADDR_L     | shifting in word-address low byte
// ADDR_L_ACK | acknowledging low byte
// WR_DATA    | shifting in a data byte to write
// WR_ACK     | acknowledging a written byte
// RD_DATA    | driving a data byte out
// RD_ACK     | SDA released, sampling master ACK/NACK
module at24c02_model
  import at24c02_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter int         PAGE_SIZE  = DEF_PAGE_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_oe,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic              busy
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int PAGE_BITS = $clog2(PAGE_SIZE);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_bus_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_state_e        state_q, state_nxt;
  logic [2:0]        bit_cnt_q, bit_cnt_nxt;
  // Only seven bits are kept: on receive the eighth arrives live from SDA,
  // on transmit the MSB is driven straight from the memory read.
  logic [6:0]        shift_q, shift_nxt;
  logic [ADDR_W-1:0] ptr_q, ptr_nxt;
  logic [ADDR_W-9:0] addr_hi_q, addr_hi_nxt;
  logic              sda_oe_q, sda_oe_nxt;
  logic              busy_q, busy_nxt;
  // In ACK states: 0 until the first SCL fall (drive), 1 until the second
  // (release). In RD_ACK: set once the master ACK has been sampled.
  logic              ack_phase_q, ack_phase_nxt;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_byte;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] ptr_page_inc;
  logic              i2c_we;

  assign rd_byte = mem[ptr_q];
  assign rx_byte = {shift_q, sda};

  always_comb begin
    ptr_page_inc                  = ptr_q;
    ptr_page_inc[PAGE_BITS-1:0]   = ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      addr_hi_q   <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      ack_phase_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      shift_q     <= shift_nxt;
      ptr_q       <= ptr_nxt;
      addr_hi_q   <= addr_hi_nxt;
      sda_oe_q    <= sda_oe_nxt;
      busy_q      <= busy_nxt;
      ack_phase_q <= ack_phase_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt_q;
    shift_nxt     = shift_q;
    ptr_nxt       = ptr_q;
    addr_hi_nxt   = addr_hi_q;
    sda_oe_nxt    = sda_oe_q;
    busy_nxt      = busy_q;
    ack_phase_nxt = ack_phase_q;
    i2c_we        = 1'b0;

    if (stop_det) begin
      state_nxt     = IDLE;
      bit_cnt_nxt   = '0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      ack_phase_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt     = DEV_ADDR;
      bit_cnt_nxt   = '0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b1;
      ack_phase_nxt = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        DEV_ADDR, ADDR_H, ADDR_L, WR_DATA: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                DEV_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) state_nxt = DEV_ACK;
                  else                            state_nxt = IDLE;
                end
                ADDR_H: begin
                  addr_hi_nxt = rx_byte[ADDR_W-9:0];
                  state_nxt   = ADDR_H_ACK;
                end
                ADDR_L: begin
                  ptr_nxt   = {addr_hi_q, rx_byte};
                  state_nxt = ADDR_L_ACK;
                end
                WR_DATA: begin
                  i2c_we    = 1'b1;
                  ptr_nxt   = ptr_page_inc;
                  state_nxt = WR_ACK;
                end
                default: ;
              endcase
            end
          end
        end

        DEV_ACK, ADDR_H_ACK, ADDR_L_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_nxt    = 1'b1;
              ack_phase_nxt = 1'b1;
            end else begin
              sda_oe_nxt    = 1'b0;
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = '0;
              case (state_q)
                DEV_ACK: begin
                  // shift_q[0] still holds the R/W bit of the address byte.
                  if (shift_q[0]) begin
                    state_nxt  = RD_DATA;
                    shift_nxt  = rd_byte[6:0];
                    sda_oe_nxt = ~rd_byte[7];
                  end else begin
                    state_nxt  = ADDR_H;
                  end
                end
                ADDR_H_ACK: state_nxt = ADDR_L;
                default:    state_nxt = WR_DATA;
              endcase
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            // Counter wraps to 0 after the 8th rise: byte fully sent.
            if (bit_cnt_q == 3'd0) begin
              sda_oe_nxt    = 1'b0;
              ack_phase_nxt = 1'b0;
              state_nxt     = RD_ACK;
            end else begin
              sda_oe_nxt = ~shift_q[6];
              shift_nxt  = {shift_q[5:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && !ack_phase_q) begin
            ptr_nxt = ptr_q + ADDR_W'(1);
            if (sda) state_nxt     = IDLE;
            else     ack_phase_nxt = 1'b1;
          end else if (scl_fall && ack_phase_q) begin
            // ptr_q has already advanced, so rd_byte is the next location.
            state_nxt     = RD_DATA;
            ack_phase_nxt = 1'b0;
            bit_cnt_nxt   = '0;
            shift_nxt     = rd_byte[6:0];
            sda_oe_nxt    = ~rd_byte[7];
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // Single write port: an I2C commit takes priority over the backdoor.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  assign mem_we    = i2c_we | bd_we;
  assign mem_waddr = i2c_we ? ptr_q   : bd_addr;
  assign mem_wdata = i2c_we ? rx_byte : bd_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bd_rdata <= '0;
    else      bd_rdata <= mem[bd_addr];
  end

  // Bus conditions release SDA combinationally, without waiting for the
  // register update.
  assign sda_oe = sda_oe_q & ~(start_det | stop_det);
  assign sda_o  = 1'b0;
  assign busy   = busy_q;

endmodule

// File: tb/tb_at24c02_model.sv
module tb_at24c02_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [7:0]  bd_wdata = '0;
  logic        sda_o;
  logic        sda_oe;
  logic [7:0]  bd_rdata;
  logic        busy;
  logic        sda_bus;
  logic        oe_seen = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  at24c02_model dut (
    .clk     (clk),
    .rst     (rst_n),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_o   (sda_o),
    .sda_oe  (sda_oe),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata),
    .busy    (busy)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } item_t;

  item_t exp_q[$];
  item_t act_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic expect_val(input string n, input logic [7:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic present(input string n, input logic [7:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    act_q.push_back(it);
  endtask

  // Monitor: compares every DUT observation against the oldest expectation.
  always @(posedge clk) begin
    item_t a;
    item_t e;
    while (act_q.size() != 0) begin
      a = act_q.pop_front();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: got %02h, no expected value queued", a.name, a.val);
      end else begin
        e = exp_q.pop_front();
        if (e.val !== a.val) begin
          n_fail++;
          $display("FAIL %s: got %02h, expected %02h", e.name, a.val, e.val);
        end
      end
    end
  end

  always @(negedge clk) if (sda_oe) oe_seen = 1'b1;

  task automatic q_wait();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_start();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic send_stop();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
    q_wait();
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b;    q_wait();
    scl_m = 1'b1; q_wait(); q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    b = sda_bus;  q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic wr_byte(input logic [7:0] d, input string n, input logic exp_ack);
    logic a;
    expect_val(n, {7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    present(n, {7'b0, a});
  endtask

  task automatic rd_byte(input logic [7:0] exp_d, input string n, input logic m_ack);
    logic [7:0] d;
    logic       b;
    expect_val(n, exp_d);
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(m_ack);
    present(n, d);
  endtask

  task automatic bd_write(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input logic [10:0] a, input logic [7:0] exp_d, input string n);
    expect_val(n, exp_d);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    present(n, bd_rdata);
  endtask

  initial begin
    logic b;

    // Reset state
    repeat (3) @(negedge clk);
    expect_val("rst_sda_oe", 8'h00);   present("rst_sda_oe", {7'b0, sda_oe});
    expect_val("rst_busy", 8'h00);     present("rst_busy", {7'b0, busy});
    expect_val("rst_bd_rdata", 8'h00); present("rst_bd_rdata", bd_rdata);
    rst_n = 1'b1;
    q_wait();

    // Byte write 0xA5 to 0x012
    send_start();
    wr_byte(8'hA0, "bw_dev_ack", 1'b0);
    expect_val("bw_busy", 8'h01); present("bw_busy", {7'b0, busy});
    wr_byte(8'h00, "bw_ah_ack", 1'b0);
    wr_byte(8'h12, "bw_al_ack", 1'b0);
    wr_byte(8'hA5, "bw_data_ack", 1'b0);
    send_stop();
    expect_val("bw_busy_stop", 8'h00); present("bw_busy_stop", {7'b0, busy});
    bd_check(11'h012, 8'hA5, "bw_mem");

    // Random read with ACK then NACK, then current-address read
    bd_write(11'h100, 8'h3C);
    bd_write(11'h101, 8'h3D);
    bd_write(11'h102, 8'h77);
    send_start();
    wr_byte(8'hA0, "rr_dev_ack", 1'b0);
    wr_byte(8'h01, "rr_ah_ack", 1'b0);
    wr_byte(8'h00, "rr_al_ack", 1'b0);
    send_start();
    wr_byte(8'hA1, "rr_devr_ack", 1'b0);
    rd_byte(8'h3C, "rr_byte0", 1'b0);
    rd_byte(8'h3D, "rr_byte1", 1'b1);
    send_stop();
    send_start();
    wr_byte(8'hA1, "cr_dev_ack", 1'b0);
    rd_byte(8'h77, "cr_byte", 1'b1);
    send_stop();

    // Page wrap: 18 bytes from 0x00E
    bd_write(11'h010, 8'h5A);
    send_start();
    wr_byte(8'hA0, "pg_dev_ack", 1'b0);
    wr_byte(8'h00, "pg_ah_ack", 1'b0);
    wr_byte(8'h0E, "pg_al_ack", 1'b0);
    for (int k = 0; k < 18; k++) wr_byte(8'(k), "pg_data_ack", 1'b0);
    send_stop();
    for (int a = 0; a < 16; a++) bd_check(11'(a), 8'(a + 2), "pg_mem");
    bd_check(11'h010, 8'h5A, "pg_next_page");

    // Address mismatch: no ACK, then bus ignored until START
    oe_seen = 1'b0;
    send_start();
    wr_byte(8'hA2, "nm_nack", 1'b1);
    expect_val("nm_busy", 8'h01); present("nm_busy", {7'b0, busy});
    wr_byte(8'hA0, "nm_idle_nack", 1'b1);
    send_stop();
    expect_val("nm_busy_stop", 8'h00); present("nm_busy_stop", {7'b0, busy});
    expect_val("nm_oe_seen", 8'h00);   present("nm_oe_seen", {7'b0, oe_seen});

    // Read wrap across top of memory
    bd_write(11'h7FF, 8'hE1);
    bd_write(11'h000, 8'hC3);
    send_start();
    wr_byte(8'hA0, "rw_dev_ack", 1'b0);
    wr_byte(8'h07, "rw_ah_ack", 1'b0);
    wr_byte(8'hFF, "rw_al_ack", 1'b0);
    send_start();
    wr_byte(8'hA1, "rw_devr_ack", 1'b0);
    rd_byte(8'hE1, "rw_byte_7ff", 1'b0);
    rd_byte(8'hC3, "rw_byte_000", 1'b1);
    send_stop();

    // Reset during bit 3 of a read byte (pointer 0x001 holds 0x03)
    send_start();
    wr_byte(8'hA1, "rs_dev_ack", 1'b0);
    rd_bit(b);
    rd_bit(b);
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    expect_val("rs_oe_mid", 8'h01); present("rs_oe_mid", {7'b0, sda_oe});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_val("rs_oe_reset", 8'h00);   present("rs_oe_reset", {7'b0, sda_oe});
    expect_val("rs_busy_reset", 8'h00); present("rs_busy_reset", {7'b0, busy});
    q_wait();
    rst_n = 1'b1;
    q_wait();
    send_start();
    wr_byte(8'hA0, "rs_dev_ack2", 1'b0);
    wr_byte(8'h02, "rs_ah_ack", 1'b0);
    wr_byte(8'h34, "rs_al_ack", 1'b0);
    wr_byte(8'h9B, "rs_data_ack", 1'b0);
    send_stop();
    bd_check(11'h234, 8'h9B, "rs_mem");

    // Drain scoreboard
    for (int i = 0; i < 50 && act_q.size() != 0; i++) @(posedge clk);
    q_wait();
    while (exp_q.size() != 0) begin
      item_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: got nothing, expected %02h", e.name, e.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
